// File: rtl/dispense_pulse_gen.sv
// ---------------------------------------------------------------------------
// dispense_pulse_gen
//   Re-expands one-cycle trig requests into fixed-width level pulses on a
//   physical output. Requests arriving while a pulse (or its trailing low gap)
//   is running are counted in a saturating pending counter and replayed in
//   order, each separated by a GAP_CYCLES low gap.
//
//   Optional feature macro: PULSE_ABORT_EN (adds the abort input, which ends
//   the current HOLD early and enters a full GAP).
//
// Ports
//   clk       in          system clock, posedge
//   rst_n     in          asynchronous active-low reset
//   trig      in          one-cycle request pulse
//   clr       in          synchronous flush of the pending queue
//   abort     in          (PULSE_ABORT_EN only) end current HOLD early
//   out       out         registered pulse output
//   busy      out         high whenever the FSM is not idle
//   pending   out [PEND_W] queued requests not yet started
//   overflow  out         one-cycle pulse when a trig is dropped at saturation
// ---------------------------------------------------------------------------
module dispense_pulse_gen #(
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = 25,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr,
`ifdef PULSE_ABORT_EN
  input  logic              abort,
`endif
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] MAX_PEND  = {PEND_W{1'b1}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              abort_s;
  logic              tdone_s;
  logic              consume_s;
  logic              enq_s;

`ifdef PULSE_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign tdone_s = (timer_q == {CNT_W{1'b0}});

  // State register: FSM state, timer, pending counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= {CNT_W{1'b0}};
      pend_q  <= {PEND_W{1'b0}};
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: FSM transitions, timer reload/decrement, queue accounting.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    consume_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = {CNT_W{1'b0}};
        // clr blocks any start; a queued entry takes precedence over trig
        if (!clr && (pend_q != {PEND_W{1'b0}} || trig)) begin
          state_d   = S_HOLD;
          timer_d   = HOLD_LOAD;
          consume_s = (pend_q != {PEND_W{1'b0}});
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (abort_s || tdone_s) begin
          state_d = S_GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (tdone_s) begin
          // a flush on the last gap cycle leaves nothing to replay
          if (!clr && pend_q != {PEND_W{1'b0}}) begin
            state_d   = S_HOLD;
            timer_d   = HOLD_LOAD;
            consume_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            timer_d = {CNT_W{1'b0}};
          end
        end else begin
          timer_d = timer_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = {CNT_W{1'b0}};
      end
    endcase

    // A trig that starts a pulse straight from an empty idle queue is not queued.
    enq_s = trig && !clr && !(state_q == S_IDLE && pend_q == {PEND_W{1'b0}});

    pend_d = pend_q;
    if (clr) begin
      pend_d = {PEND_W{1'b0}};
    end else if (enq_s && !consume_s) begin
      if (pend_q != MAX_PEND) begin
        pend_d = pend_q + {{(PEND_W-1){1'b0}}, 1'b1};
      end else begin
        pend_d = pend_q;
      end
    end else if (consume_s && !enq_s) begin
      pend_d = pend_q - {{(PEND_W-1){1'b0}}, 1'b1};
    end else begin
      pend_d = pend_q;
    end
  end

  // Output logic: outputs for the next cycle, derived from the next state.
  always_comb begin
    out_d  = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
    if (!clr && enq_s && !consume_s && pend_q == MAX_PEND) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = 1'b0;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
